ls161_chain: RTL
================

Name: ls161_chain

Overview:
- Synchronous binary counter built from STAGES cascaded 74LS161 4-bit counters, with async clear, sync parallel load and per-stage ripple-carry outputs.
- Cycle-accurate to the discrete chip chain.
- Used for the System86 video H/V timing and address counters.
- Sits directly upstream of the LS02 NOR decode gates, which consume its Q and RCO outputs.

Parameters:
- STAGES, 2, number of cascaded 4-bit LS161 stages (1..4); counter width W = 4*STAGES.
- MATCH_VALUE, 0, W-bit compare value for the optional decode output.

Ports:
- CLK  in  1  rising-edge clock, common to all stages
- CLR_n  in  1  asynchronous active-low clear, all stages
- LOAD_n  in  1  synchronous active-low parallel load
- ENP  in  1  count enable P, common to all stages
- ENT  in  1  count enable T, into stage 0 only
- D  in  W  parallel load data; stage k uses D[4k+3:4k]
- Q  out  W  counter value; stage k drives Q[4k+3:4k]
- RCO_STAGE  out  STAGES  ripple-carry out of each stage
- RCO  out  1  ripple-carry out of the final stage (= RCO_STAGE[STAGES-1])
- MATCH  out  1  registered decode of Q == MATCH_VALUE (optional feature)

Behaviour:
- Interface (already decided): one clock, CLK; reset CLR_n is asynchronous and active-low.
- Reset: CLR_n low forces Q = 0 immediately, independent of CLK, and holds while low. MATCH = 0. RCO_STAGE = 0 and RCO = 0, since Q = 0 ≠ 15 per stage.
- CLR_n may be asserted mid-count or mid-load; it always wins.
- On release of CLR_n, the first rising CLK edge with CLR_n high acts normally.
- Per-stage enable T:
  - ENT_0 = ENT.
  - ENT_k = RCO_STAGE[k-1] for k ≥ 1.
- Per-stage carry: RCO_STAGE[k] = ENT_k AND (stage k Q == 4'hF). This is combinational, with no clock delay, matching the LS161.
- Priority on each rising CLK edge, per stage, with CLR_n high:
  1. LOAD_n = 0: stage Q <= D slice. Overrides ENP/ENT; all stages load together.
  2. ENP = 1 and ENT_k = 1: stage Q <= Q + 1 mod 16 (F wraps to 0).
  3. Otherwise: hold.
- Whole chain counts W-bit binary. Full wrap: all-ones -> 0 in one clock when ENP = ENT = 1.
- ENP low freezes all stages but does not gate RCO. RCO depends on ENT only, as on the real chip, so RCO can be high while the counter holds.
- Load of 4'hF into a stage with ENT_k high makes RCO_STAGE[k] high in the same cycle, after the edge.
- Latency:
  - Count/load: Q valid after the CLK edge, one cycle.
  - RCO: combinational from Q and ENT.
  - MATCH: one cycle after Q.
- No X propagation: all state registers reset by CLR_n.

Optional Feature:
- Macro: LS161_MATCH_DECODE_EN.
- Defined: MATCH is a register updated every CLK edge as MATCH <= (Q == MATCH_VALUE), using the Q value before the edge. It is therefore high for exactly the cycle after Q equals MATCH_VALUE. Cleared asynchronously by CLR_n.
- Not defined: no comparator or register is built, and MATCH is tied to 0. The port list is unchanged.

Test Plan:
- Async clear: STAGES=2, count to 8'h37, drop CLR_n between clock edges -> Q = 8'h00 and RCO = 0 without a CLK edge. Pulse CLK with CLR_n low -> Q stays 8'h00.
- Count and cascade: ENP=ENT=1 from 8'h0E -> 8'h0F (RCO_STAGE = 2'b01), then 8'h10 (RCO_STAGE = 2'b00). From 8'hFE -> 8'hFF (RCO = 1), then 8'h00.
- Load priority: Q = 8'h12, LOAD_n = 0, ENP = ENT = 1, D = 8'hA5 -> Q = 8'hA5 after one edge, no increment. LOAD_n = 0 with ENP = 0 also loads.
- Enable gating: Q = 8'hFF, ENP = 0, ENT = 1 -> Q holds 8'hFF and RCO = 1. ENT = 0 -> RCO = 0 immediately, and Q holds even with ENP = 1.
- Match decode (macro defined, MATCH_VALUE = 8'h40): count through 8'h40 -> MATCH high exactly the one cycle when Q = 8'h41. Macro undefined -> MATCH = 0 throughout.
- Reset mid-load: assert CLR_n low coincident with LOAD_n = 0, D = 8'hFF edge -> Q = 8'h00. Release, then next edge loads 8'hFF.

Source files
------------

// File: rtl/ls161_chain.sv
// ls161_chain: STAGES cascaded 74LS161 4-bit counters with async clear, sync load and ripple carry.
// Define LS161_MATCH_DECODE_EN to build the registered Q == MATCH_VALUE decode on MATCH.
module ls161_chain #(
  parameter int STAGES = 2,
  parameter logic [4*STAGES-1:0] MATCH_VALUE = '0
) (
  input  logic                  CLK,
  input  logic                  CLR_n,
  input  logic                  LOAD_n,
  input  logic                  ENP,
  input  logic                  ENT,
  input  logic [4*STAGES-1:0]   D,
  output logic [4*STAGES-1:0]   Q,
  output logic [STAGES-1:0]     RCO_STAGE,
  output logic                  RCO,
  output logic                  MATCH
);
  logic [STAGES-1:0] ent;
  logic [3:0] q [STAGES];
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign ent[k] = ENT;
    end else begin : g_next
      assign ent[k] = RCO_STAGE[k-1];
    end
    // carry is combinational from ENT and Q, so it can be high while ENP freezes the count
    assign RCO_STAGE[k] = ent[k] & (q[k] == 4'hF);
    assign Q[4*k +: 4] = q[k];
    always_ff @(posedge CLK or negedge CLR_n)
      if (!CLR_n) q[k] <= 4'h0;
      else if (!LOAD_n) q[k] <= D[4*k +: 4];
      else if (ENP && ent[k]) q[k] <= q[k] + 4'h1;
  end
  assign RCO = RCO_STAGE[STAGES-1];
`ifdef LS161_MATCH_DECODE_EN
  always_ff @(posedge CLK or negedge CLR_n)
    if (!CLR_n) MATCH <= 1'b0;
    else MATCH <= (Q == MATCH_VALUE);
`else
  assign MATCH = 1'b0;
`endif
endmodule
